// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO drain path.
// Skid depth is fixed at 2; occupancy counters are sized from it.
package fifo_pkg;
    localparam int DFLT_FIFO_WIDTH = 16;
    localparam int SKID_DEPTH      = 2;
    localparam int OCC_W           = $clog2(SKID_DEPTH + 1);

    typedef logic [DFLT_FIFO_WIDTH-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: in-order storage with write and pop ports.
// Write lands at tail and is visible at head next cycle; caller must not write when full without popping.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int W = DFLT_FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [W-1:0]     wr_dat_i,
    input  logic             pop_i,
    output logic             vld_o,
    output logic [W-1:0]     rd_dat_o,
    output logic [OCC_W-1:0] count_o
);

    logic [W-1:0]     mem_q [SKID_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ wr_en_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        occ_d    = occ_q;
        case ({wr_en_i, pop_i})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Storage is cleared on reset so the output word reads as zero when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_dat_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign vld_o    = (occ_q != '0);
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign count_o  = occ_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en_i && !pop_i && (occ_q == OCC_W'(SKID_DEPTH))));
    a_no_underrun: assert property (@(posedge clk) disable iff (rst)
        pop_i |-> (occ_q != '0));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// FIFO consumer: gates rd_en on skid-buffer room, captures data_out a cycle later, streams it out.
// Optional saturating underflow counter under FIFO_DRAIN_UFLOW_CNT_EN.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH  = DFLT_FIFO_WIDTH,
    parameter int SKID_DEPTH  = 2,
    parameter int UFLOW_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   drain_en,
    input  logic                   fifo_empty,
    input  logic                   fifo_underflow,
    input  logic [FIFO_WIDTH-1:0]  fifo_data,
    output logic                   fifo_rd_en,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [FIFO_WIDTH-1:0]  m_data,
    output logic                   idle
`ifdef FIFO_DRAIN_UFLOW_CNT_EN
    ,
    output logic [UFLOW_CNT_W-1:0] uflow_cnt
`endif
);

    logic             inflight_q, inflight_d;
    logic             pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   demand;

    assign pop = m_valid && m_ready;

    // Room check counts the word already on the FIFO data bus, credited by this cycle's pop.
    assign demand     = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
    assign fifo_rd_en = drain_en && !fifo_empty && !rst && (demand < (OCC_W+1)'(SKID_DEPTH));
    assign inflight_d = fifo_rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_skid_buf #(
        .W (FIFO_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (inflight_q),
        .wr_dat_i (fifo_data),
        .pop_i    (pop),
        .vld_o    (m_valid),
        .rd_dat_o (m_data),
        .count_o  (occ)
    );

    assign idle = (occ == '0) && !inflight_q;

`ifdef FIFO_DRAIN_UFLOW_CNT_EN
    logic [UFLOW_CNT_W-1:0] uflow_cnt_q, uflow_cnt_d;

    always_comb begin
        uflow_cnt_d = uflow_cnt_q;
        if (fifo_underflow && !(&uflow_cnt_q)) begin
            uflow_cnt_d = uflow_cnt_q + UFLOW_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uflow_cnt_q <= '0;
        end else begin
            uflow_cnt_q <= uflow_cnt_d;
        end
    end

    assign uflow_cnt = uflow_cnt_q;
`else
    logic unused_uflow;
    assign unused_uflow = fifo_underflow;
`endif

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Downstream consumer stage for the synchronous FIFO. It issues `rd_en` toward the FIFO and captures `data_out` one cycle after each accepted read. It re-presents the words on a valid/ready stream through a 2-entry skid buffer, so a stalling sink never loses a word already in flight. It also monitors the FIFO `underflow` flag as a protocol-error indicator.

## Interface
Parameters:
- `FIFO_WIDTH`, 16, data word width; must match the FIFO.
- `SKID_DEPTH`, 2, skid buffer entries; fixed at 2 in this revision.
- `UFLOW_CNT_W`, 8, width of the saturating underflow counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `drain_en`  in  1  1 = issue reads; 0 = issue no new reads; in-flight and buffered words still drain.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_underflow`  in  1  FIFO `underflow`.
- `fifo_data`  in  FIFO_WIDTH  FIFO `data_out`; valid the cycle after an accepted read.
- `fifo_rd_en`  out  1  read strobe to FIFO; combinational.
- `m_valid`  out  1  output word valid; registered.
- `m_ready`  in  1  sink accepts when `m_valid && m_ready`.
- `m_data`  out  FIFO_WIDTH  output word, head of skid buffer.
- `idle`  out  1  no word in flight and buffer empty.
- `uflow_cnt`  out  UFLOW_CNT_W  saturating underflow event count; present only with `FIFO_DRAIN_UFLOW_CNT_EN`.

## Operation
- State: `inflight` (0/1), `occ` (0..2) entries, head/tail pointers (1 bit each), 2×FIFO_WIDTH storage.
- `pop = m_valid && m_ready`.
- `fifo_rd_en = drain_en && !fifo_empty && !rst && (occ + inflight - pop) < 2`.
- `inflight` next = `fifo_rd_en`. When `inflight` is 1, `fifo_data` is written at tail and the tail advances.
- Pop advances head. Simultaneous write and pop: `occ` is unchanged. `occ` never exceeds 2; exceeding it is an assertion failure.
- `m_valid = (occ != 0)`. `m_data` = storage[head]. `m_data` holds stable while `m_valid && !m_ready`.
- Pointers wrap modulo 2.
- `drain_en` deassert: `fifo_rd_en` drops the same cycle. A pending in-flight word is still captured, and the buffer keeps emptying to the sink.
- `idle = (occ == 0) && !inflight`.
- `fifo_underflow` high for a cycle: counter +1, saturating at all-ones. With correct gating this never occurs.

## Timing
- Reset values: `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `idle` 1, `uflow_cnt` 0. `occ`, `inflight` and pointers are 0.
- Reset mid-operation discards the in-flight word and buffered contents. The FIFO keeps its own state, and no read is issued during reset.
- Latency: `fifo_rd_en` in cycle N → `fifo_data` in N+1 → `m_valid` in N+2.
- Throughput: one word per cycle sustained with `m_ready` held high and the FIFO non-empty.
- After `m_ready` drops, at most 1 further read issues. The buffer fills to 2, then `fifo_rd_en` stays 0 until a pop.

## Configuration
- `FIFO_DRAIN_UFLOW_CNT_EN` defined: `uflow_cnt` port and counter exist.
- Not defined: port and counter are removed; `fifo_underflow` is ignored. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg`: `FIFO_WIDTH` default, `SKID_DEPTH`, typedef `fifo_word_t` (logic [FIFO_WIDTH-1:0]).
- One sub-module `fifo_skid_buf`: 2-entry storage, pointers, `occ`, write/pop ports, `count` output. The top module holds the read gating, `inflight` and the counter.

## Test plan
- Reset: assert `rst` for 2 cycles with FIFO non-empty → `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `idle`=1 throughout.
- Streaming: FIFO preloaded 0x0001..0x0008, `m_ready`=1 → reads in cycles 0..7; `m_data` 0x0001..0x0008 on consecutive cycles 2..9; `idle`=1 at cycle 10.
- Backpressure: `m_ready`=0 from cycle 3 → exactly 2 words buffered, `fifo_rd_en` 0 from then on, `m_data` held. Release → order preserved, no loss or duplicate.
- Drain disable: `drain_en`→0 with a read just issued → that word still appears on `m_data`; no further `fifo_rd_en`; `idle`=1 once it is popped.
- Reset mid-stream: `rst` with `occ`=2 and `inflight`=1 → next cycle `m_valid`=0 and `occ`=0; after release, reads resume from the FIFO's current head.
- Underflow counter (macro on): pulse `fifo_underflow` 300 times with `UFLOW_CNT_W`=8 → `uflow_cnt`=255. Macro off → port absent and the build passes.
